fft_control_radix2: RTL and testbench
=====================================

# fft_control_radix2

Parametrised control unit for an in-place radix-2 DIT FFT of 2^LOG2N points over a single-butterfly datapath and a dual-port work buffer. It issues one butterfly per cycle, tracks in-flight results in an internal write-address FIFO, and applies a stage barrier so no stage reads data still being written by the previous one. It sits between the FFT top-level sequencer (start/done) and the butterfly, twiddle ROM and buffer.

## Interface
- LOG2N, 3, log2 of FFT size N (legal 2..10)
- MAX_OUTSTANDING, 16, max butterflies in flight (power of two, ≥2); sets tag-FIFO depth
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin transform; sampled in IDLE only
- inverse  in  1  inverse-transform request, latched on accepted start
- butterfly_valid  in  1  one pulse per issued butterfly, in issue order
- busy  out  1  high in ISSUE and DRAIN
- done  out  1  one-cycle pulse in DONE
- protocol_err  out  1  sticky: butterfly_valid seen with nothing in flight; cleared on accepted start
- butterfly_enable  out  1  issue strobe; rd_addr_x/y and twiddle valid this cycle
- rd_addr_x, rd_addr_y  out  LOG2N  buffer read addresses
- twiddle_addr  out  LOG2N-1  twiddle ROM index k of W_N^k
- twiddle_conj  out  1  conjugate twiddle (inverse mode)
- wr_en  out  1  equals butterfly_valid when FIFO non-empty
- wr_addr_0, wr_addr_1  out  LOG2N  write addresses, FIFO head
- current_stage  out  max(1,clog2(LOG2N))  stage being issued
- butterfly_idx  out  LOG2N-1  butterfly index within stage

## Operation
- States: IDLE, ISSUE, DRAIN, DONE. IDLE→ISSUE on start (stage=0, idx=0, outstanding=0, protocol_err=0, inverse latched). ISSUE→DRAIN after last idx (N/2-1) of a stage issued. DRAIN→ISSUE (stage+1, idx=0) when outstanding reaches 0 and stage<LOG2N-1; →DONE if last stage. DONE→IDLE unconditionally.
- Address map, stage s, butterfly b: span=N>>(s+1); grp=b>>(LOG2N-1-s); pos=b&(span-1); x=grp·2·span+pos; y=x+span; twiddle_addr=(b&((1<<s)-1))<<(LOG2N-1-s). wr_addr_0=x, wr_addr_1=y (in-place).
- Issue: in ISSUE, butterfly_enable=1 when outstanding<MAX_OUTSTANDING; pushes {x,y}, idx increments. When full, enable=0 and idx holds.
- Retire: butterfly_valid with FIFO non-empty → wr_en=1, wr_addr_* = head, pop same cycle. Simultaneous issue and retire: count unchanged, FIFO push+pop both performed.
- butterfly_valid with FIFO empty: no write, protocol_err set, state unaffected.
- start while not IDLE ignored. inverse changes after start ignored.
- Address/twiddle outputs are combinational from stage/idx; don't-care when enable=0.

## Timing
- Reset: state IDLE, all outputs 0, counters/FIFO cleared; reset mid-transform aborts immediately, no done.
- start sampled at edge T in IDLE → first butterfly_enable in cycle T+1.
- Stage s issues N/2 butterflies in N/2 consecutive cycles if not stalled.
- wr_en same cycle as butterfly_valid (zero latency); write addresses combinational from FIFO head.
- Next stage's first issue is the cycle after the last retire of the current stage.
- done asserts the cycle after the final retire; busy low that cycle.

## Configuration
- FFT_CTRL_INVERSE_EN defined: twiddle_conj = latched inverse throughout busy, 0 in IDLE/DONE.
- Undefined: inverse ignored, no latch, twiddle_conj tied 0.

## Test plan
- LOG2N=3, butterfly model latency 11, start pulse → 12 enables in order (x,y): stage0 (0,4)(1,5)(2,6)(3,7), stage1 (0,2)(1,3)(4,6)(5,7) twiddle 0,2,0,2, stage2 (0,1)(2,3)(4,5)(6,7) twiddle 0,1,2,3; done once, 3·(4+11)+1 cycles after start edge.
- MAX_OUTSTANDING=2, latency 5 → never more than 2 enables without retire; wr addresses match issue order; result identical to unstalled run.
- Latency 1 (valid with each next-cycle issue) → simultaneous push/pop, outstanding ≤1, no stage issues before prior stage's last wr_en.
- Extra butterfly_valid in IDLE → protocol_err=1, wr_en=0; next start clears it.
- rst_n low mid-stage1 → all outputs 0 immediately; new start restarts stage0 idx0.
- FFT_CTRL_INVERSE_EN, start with inverse=1 then inverse=0 → twiddle_conj=1 for whole transform; without macro twiddle_conj=0.

Source files
------------

// File: rtl/fft_control_radix2.sv
// Control unit for an in-place radix-2 DIT FFT over one butterfly and a dual-port buffer.
// Define FFT_CTRL_INVERSE_EN to latch the inverse request and drive twiddle_conj.
module fft_control_radix2 #(
    parameter int LOG2N           = 3,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start,
    input  logic                                          inverse,
    input  logic                                          butterfly_valid,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          protocol_err,
    output logic                                          butterfly_enable,
    output logic [LOG2N-1:0]                              rd_addr_x,
    output logic [LOG2N-1:0]                              rd_addr_y,
    output logic [LOG2N-2:0]                              twiddle_addr,
    output logic                                          twiddle_conj,
    output logic                                          wr_en,
    output logic [LOG2N-1:0]                              wr_addr_0,
    output logic [LOG2N-1:0]                              wr_addr_1,
    output logic [((LOG2N > 1) ? $clog2(LOG2N) : 1)-1:0]  current_stage,
    output logic [LOG2N-2:0]                              butterfly_idx
);

    localparam int N  = 1 << LOG2N;
    localparam int AW = LOG2N;
    localparam int IW = LOG2N - 1;
    localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    localparam logic [AW-1:0] HALF       = AW'(N / 2);
    localparam logic [IW-1:0] LAST_IDX   = IW'(N / 2 - 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2N - 1);
    localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            err_q, err_d;
    logic [2*AW-1:0] fifo_mem [MAX_OUTSTANDING];
    logic [2*AW-1:0] fifo_head;

    logic            push, pop, fifo_empty;
    int              s_int;
    logic [AW-1:0]   b_ext, span, grp, pos, x_addr, y_addr;
    logic [IW-1:0]   tw_mask, tw_addr;

    // Butterfly address map for the current stage and index.
    always_comb begin
        s_int   = int'(stage_q);
        b_ext   = {1'b0, idx_q};
        span    = HALF >> s_int;
        grp     = b_ext >> (AW - 1 - s_int);
        pos     = b_ext & (span - AW'(1));
        x_addr  = (grp << (AW - s_int)) | pos;
        y_addr  = x_addr + span;
        tw_mask = (IW'(1) << s_int) - IW'(1);
        tw_addr = (idx_q & tw_mask) << (IW - s_int);
    end

    assign fifo_empty       = (count_q == '0);
    assign butterfly_enable = (state_q == S_ISSUE) && (count_q < MAX_CNT);
    assign push             = butterfly_enable;
    assign pop              = butterfly_valid && !fifo_empty;
    assign fifo_head        = fifo_mem[rd_ptr_q];

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        idx_d    = idx_q;
        err_d    = err_q;
        count_d  = count_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (butterfly_valid && fifo_empty) err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_ISSUE;
                    stage_d  = '0;
                    idx_d    = '0;
                    count_d  = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    err_d    = 1'b0;
                end
            end
            S_ISSUE: begin
                if (butterfly_enable) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Barrier: the next stage may start only once its inputs are all written back.
                if (count_d == '0) begin
                    if (stage_q == LAST_STAGE) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        stage_d = stage_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                stage_d = '0;
                idx_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            stage_q  <= '0;
            idx_q    <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

    // NOTE: the tag storage is not reset; the count marks valid entries and outputs are masked when empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {x_addr, y_addr};
    end

`ifdef FFT_CTRL_INVERSE_EN
    logic inverse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        inverse_q <= 1'b0;
        else if (state_q == S_IDLE && start) inverse_q <= inverse;
    end

    assign twiddle_conj = inverse_q && busy;
`else
    logic unused_inverse;
    assign unused_inverse = inverse;
    assign twiddle_conj   = 1'b0;
`endif

    assign busy          = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);
    assign protocol_err  = err_q;
    assign rd_addr_x     = butterfly_enable ? x_addr  : '0;
    assign rd_addr_y     = butterfly_enable ? y_addr  : '0;
    assign twiddle_addr  = butterfly_enable ? tw_addr : '0;
    assign wr_en         = pop;
    assign wr_addr_0     = fifo_empty ? '0 : fifo_head[2*AW-1:AW];
    assign wr_addr_1     = fifo_empty ? '0 : fifo_head[AW-1:0];
    assign current_stage = stage_q;
    assign butterfly_idx = idx_q;

endmodule

// File: tb/tb_fft_control_radix2.sv
// Directed bench for fft_control_radix2: an unstalled unit (A) and a MAX_OUTSTANDING=2 unit (B),
// each driven by a fixed-latency butterfly model.
module tb_fft_control_radix2;

    localparam int LOG2N = 3;
    localparam int NB    = 12;
    localparam int SW    = 2;

`ifdef FFT_CTRL_INVERSE_EN
    localparam int CONJ_ON = 1;
`else
    localparam int CONJ_ON = 0;
`endif

    typedef struct {int x; int y; int tw; int st; int conj; int cyc;} iss_t;
    typedef struct {int a0; int a1; int cyc;} wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_n, start_a, start_b, inverse_a, inverse_b, extra_a;
    int   lat_a, lat_b;
    logic [31:0] pipe_a, pipe_b;
    logic valid_a, valid_b;

    logic busy_a, done_a, err_a, en_a, conj_a, wen_a;
    logic busy_b, done_b, err_b, en_b, conj_b, wen_b;
    logic [LOG2N-1:0] rdx_a, rdy_a, wa0_a, wa1_a, rdx_b, rdy_b, wa0_b, wa1_b;
    logic [LOG2N-2:0] tw_a, idx_a, tw_b, idx_b;
    logic [SW-1:0]    st_a, st_b;

    int ex  [NB] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    int ey  [NB] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
    int etw [NB] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    int n_checks = 0;
    int n_fail   = 0;

    // Butterfly models: a result appears exactly lat cycles after its issue.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_a <= '0;
            pipe_b <= '0;
        end else begin
            pipe_a <= {pipe_a[30:0], en_a};
            pipe_b <= {pipe_b[30:0], en_b};
        end
    end
    assign valid_a = pipe_a[lat_a-1] | extra_a;
    assign valid_b = pipe_b[lat_b-1];

    fft_control_radix2 #(.LOG2N(LOG2N), .MAX_OUTSTANDING(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .inverse(inverse_a),
        .butterfly_valid(valid_a), .busy(busy_a), .done(done_a), .protocol_err(err_a),
        .butterfly_enable(en_a), .rd_addr_x(rdx_a), .rd_addr_y(rdy_a),
        .twiddle_addr(tw_a), .twiddle_conj(conj_a), .wr_en(wen_a),
        .wr_addr_0(wa0_a), .wr_addr_1(wa1_a), .current_stage(st_a), .butterfly_idx(idx_a)
    );

    fft_control_radix2 #(.LOG2N(LOG2N), .MAX_OUTSTANDING(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .inverse(inverse_b),
        .butterfly_valid(valid_b), .busy(busy_b), .done(done_b), .protocol_err(err_b),
        .butterfly_enable(en_b), .rd_addr_x(rdx_b), .rd_addr_y(rdy_b),
        .twiddle_addr(tw_b), .twiddle_conj(conj_b), .wr_en(wen_b),
        .wr_addr_0(wa0_b), .wr_addr_1(wa1_b), .current_stage(st_b), .butterfly_idx(idx_b)
    );

    // Monitor: cycles are numbered by their closing clock edge.
    iss_t iss_a[$], iss_b[$];
    wr_t  wr_a[$], wr_b[$];
    iss_t ir_m;
    wr_t  wr_m;
    int   done_a_n, done_a_cyc, done_a_busy, out_a, max_out_a;
    int   done_b_n, out_b, max_out_b;

    always @(negedge clk) begin
        if (!rst_n) begin
            out_a = 0;
            out_b = 0;
        end
        if (en_a) begin
            ir_m.x = int'(rdx_a); ir_m.y = int'(rdy_a); ir_m.tw = int'(tw_a);
            ir_m.st = int'(st_a); ir_m.conj = int'(conj_a); ir_m.cyc = cyc + 1;
            iss_a.push_back(ir_m);
        end
        if (wen_a) begin
            wr_m.a0 = int'(wa0_a); wr_m.a1 = int'(wa1_a); wr_m.cyc = cyc + 1;
            wr_a.push_back(wr_m);
        end
        if (done_a) begin
            done_a_n++;
            done_a_cyc  = cyc + 1;
            done_a_busy = int'(busy_a);
        end
        out_a = out_a + int'(en_a) - int'(wen_a);
        if (out_a > max_out_a) max_out_a = out_a;
        if (en_b) begin
            ir_m.x = int'(rdx_b); ir_m.y = int'(rdy_b); ir_m.tw = int'(tw_b);
            ir_m.st = int'(st_b); ir_m.conj = int'(conj_b); ir_m.cyc = cyc + 1;
            iss_b.push_back(ir_m);
        end
        if (wen_b) begin
            wr_m.a0 = int'(wa0_b); wr_m.a1 = int'(wa1_b); wr_m.cyc = cyc + 1;
            wr_b.push_back(wr_m);
        end
        if (done_b) done_b_n++;
        out_b = out_b + int'(en_b) - int'(wen_b);
        if (out_b > max_out_b) max_out_b = out_b;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {a[7:0], b[7:0], c[7:0], d[7:0]};
    endfunction

    // Inputs change 1 time unit after the falling edge, after the monitor has sampled.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_records();
        iss_a.delete(); wr_a.delete(); iss_b.delete(); wr_b.delete();
        done_a_n = 0; done_a_cyc = -1; done_a_busy = -1; max_out_a = 0;
        done_b_n = 0; max_out_b = 0;
    endtask

    // Compares the recorded issue/retire streams of one unit against the reference order.
    task automatic check_seq(input string p, input bit use_b, input int t0, input int period,
                             input int lat, input int exp_conj);
        iss_t r;
        wr_t  w;
        int   n_i, n_w;
        n_i = use_b ? iss_b.size() : iss_a.size();
        n_w = use_b ? wr_b.size()  : wr_a.size();
        check({p, "_n_issue"}, n_i, NB);
        check({p, "_n_write"}, n_w, NB);
        for (int i = 0; i < NB; i++) begin
            r = '{-1, -1, -1, -1, -1, -1};
            w = '{-1, -1, -1};
            if (i < n_i) r = use_b ? iss_b[i] : iss_a[i];
            if (i < n_w) w = use_b ? wr_b[i]  : wr_a[i];
            check($sformatf("%s_issue%0d", p, i), pack4(r.x, r.y, r.tw, r.st),
                  pack4(ex[i], ey[i], etw[i], i / 4));
            check($sformatf("%s_conj%0d", p, i), r.conj, exp_conj);
            check($sformatf("%s_wr%0d", p, i), pack4(w.a0, w.a1, 0, 0), pack4(ex[i], ey[i], 0, 0));
            check($sformatf("%s_wrlat%0d", p, i), w.cyc - r.cyc, lat);
            if (period > 0)
                check($sformatf("%s_cyc%0d", p, i), r.cyc, t0 + 1 + (i / 4) * period + (i % 4));
        end
    endtask

    int t0;

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; inverse_a = 1'b0; inverse_b = 1'b0;
        extra_a = 1'b0; lat_a = 11; lat_b = 5;
        clear_records();
        repeat (2) tick();

        check("rst_outs_a", {busy_a, done_a, err_a, en_a, conj_a, wen_a, rdx_a, rdy_a, tw_a,
                             wa0_a, wa1_a, st_a, idx_a}, '0);
        check("rst_outs_b", {busy_b, done_b, err_b, en_b, conj_b, wen_b, rdx_b, rdy_b, tw_b,
                             wa0_b, wa1_b, st_b, idx_b}, '0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Latency 11 on A with inverse then dropped; latency 5 on the stalling unit B.
        clear_records();
        t0 = cyc + 1;
        start_a = 1'b1; inverse_a = 1'b1; start_b = 1'b1;
        tick();
        start_a = 1'b0; inverse_a = 1'b0; start_b = 1'b0;
        repeat (18) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (60) tick();
        check_seq("lat11", 1'b0, t0, 15, 11, CONJ_ON);
        check("lat11_done_n", done_a_n, 1);
        check("lat11_done_cyc", done_a_cyc, t0 + 46);
        check("lat11_busy_at_done", done_a_busy, 0);
        check("lat11_idle_conj", {busy_a, conj_a}, 2'b00);
        check_seq("stall", 1'b1, t0, 0, 5, 0);
        check("stall_max_out", max_out_b, 2);
        check("stall_done_n", done_b_n, 1);

        // Latency 1: every retire coincides with the next issue.
        clear_records();
        lat_a = 1;
        t0 = cyc + 1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (30) tick();
        check_seq("lat1", 1'b0, t0, 5, 1, 0);
        check("lat1_max_out", max_out_a, 1);
        check("lat1_barrier1", (iss_a.size() > 4 && wr_a.size() > 3) ? (iss_a[4].cyc > wr_a[3].cyc) : 1'b0, 1'b1);
        check("lat1_barrier2", (iss_a.size() > 8 && wr_a.size() > 7) ? (iss_a[8].cyc > wr_a[7].cyc) : 1'b0, 1'b1);
        check("lat1_done_cyc", done_a_cyc, t0 + 16);

        // Stray butterfly_valid in IDLE.
        lat_a = 11;
        extra_a = 1'b1;
        #1;
        check("stray_wr_en", wen_a, 1'b0);
        tick();
        extra_a = 1'b0;
        check("stray_err", {err_a, busy_a}, 2'b10);
        tick();
        check("stray_err_sticky", err_a, 1'b1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("start_clears_err", {err_a, en_a}, 2'b01);

        // Abort in stage 1, then restart from scratch.
        for (int k = 0; k < 60 && !(st_a == 2'd1 && en_a); k++) tick();
        check("abort_reached_s1", {st_a, en_a}, 3'b011);
        rst_n = 1'b0;
        #1;
        check("abort_outs", {busy_a, done_a, err_a, en_a, conj_a, wen_a, rdx_a, rdy_a, tw_a,
                             wa0_a, wa1_a, st_a, idx_a}, '0);
        clear_records();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("abort_no_done", {done_a_n[7:0], busy_a}, 9'd0);
        clear_records();
        t0 = cyc + 1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (60) tick();
        check_seq("restart", 1'b0, t0, 15, 11, 0);
        check("restart_done_n", done_a_n, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
